// File: rtl/camellia_sbox_array.sv
// Pipelined Camellia S-box array: LANES byte lanes, each applying s1..s4 derived from
// one synchronous-read SBOX1 ROM, with a valid/ready handshake and optional output register.
module camellia_sbox_array #(
   parameter int LANES   = 8,
   parameter int OUT_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*LANES-1:0]   in_data,
   input  logic [2*LANES-1:0]   in_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_data
);

   localparam logic [7:0] SBOX1 [256] = '{
      8'd112, 8'd130, 8'd44,  8'd236, 8'd179, 8'd39,  8'd192, 8'd229, 8'd228, 8'd133, 8'd87,  8'd53,  8'd234, 8'd12,  8'd174, 8'd65,
      8'd35,  8'd239, 8'd107, 8'd147, 8'd69,  8'd25,  8'd165, 8'd33,  8'd237, 8'd14,  8'd79,  8'd78,  8'd29,  8'd101, 8'd146, 8'd189,
      8'd134, 8'd184, 8'd175, 8'd143, 8'd124, 8'd235, 8'd31,  8'd206, 8'd62,  8'd48,  8'd220, 8'd95,  8'd94,  8'd197, 8'd11,  8'd26,
      8'd166, 8'd225, 8'd57,  8'd202, 8'd213, 8'd71,  8'd93,  8'd61,  8'd217, 8'd1,   8'd90,  8'd214, 8'd81,  8'd86,  8'd108, 8'd77,
      8'd139, 8'd13,  8'd154, 8'd102, 8'd251, 8'd204, 8'd176, 8'd45,  8'd116, 8'd18,  8'd43,  8'd32,  8'd240, 8'd177, 8'd132, 8'd153,
      8'd223, 8'd76,  8'd203, 8'd194, 8'd52,  8'd126, 8'd118, 8'd5,   8'd109, 8'd183, 8'd169, 8'd49,  8'd209, 8'd23,  8'd4,   8'd215,
      8'd20,  8'd88,  8'd58,  8'd97,  8'd222, 8'd27,  8'd17,  8'd28,  8'd50,  8'd15,  8'd156, 8'd22,  8'd83,  8'd24,  8'd242, 8'd34,
      8'd254, 8'd68,  8'd207, 8'd178, 8'd195, 8'd181, 8'd122, 8'd145, 8'd36,  8'd8,   8'd232, 8'd168, 8'd96,  8'd252, 8'd105, 8'd80,
      8'd170, 8'd208, 8'd160, 8'd125, 8'd161, 8'd137, 8'd98,  8'd151, 8'd84,  8'd91,  8'd30,  8'd149, 8'd224, 8'd255, 8'd100, 8'd210,
      8'd16,  8'd196, 8'd0,   8'd72,  8'd163, 8'd247, 8'd117, 8'd219, 8'd138, 8'd3,   8'd230, 8'd218, 8'd9,   8'd63,  8'd221, 8'd148,
      8'd135, 8'd92,  8'd131, 8'd2,   8'd205, 8'd74,  8'd144, 8'd51,  8'd115, 8'd103, 8'd246, 8'd243, 8'd157, 8'd127, 8'd191, 8'd226,
      8'd82,  8'd155, 8'd216, 8'd38,  8'd200, 8'd55,  8'd198, 8'd59,  8'd129, 8'd150, 8'd111, 8'd75,  8'd19,  8'd190, 8'd99,  8'd46,
      8'd233, 8'd121, 8'd167, 8'd140, 8'd159, 8'd110, 8'd188, 8'd142, 8'd41,  8'd245, 8'd249, 8'd182, 8'd47,  8'd253, 8'd180, 8'd89,
      8'd120, 8'd152, 8'd6,   8'd106, 8'd231, 8'd70,  8'd113, 8'd186, 8'd212, 8'd37,  8'd171, 8'd66,  8'd136, 8'd162, 8'd141, 8'd250,
      8'd114, 8'd7,   8'd185, 8'd85,  8'd248, 8'd238, 8'd172, 8'd10,  8'd54,  8'd73,  8'd42,  8'd104, 8'd60,  8'd56,  8'd241, 8'd164,
      8'd64,  8'd40,  8'd211, 8'd123, 8'd187, 8'd201, 8'd67,  8'd193, 8'd21,  8'd227, 8'd173, 8'd244, 8'd119, 8'd199, 8'd128, 8'd158
   };

   logic               v1_r;
   logic               adv1_s;
   logic               accept_s;
   logic [8*LANES-1:0] rot_all_s;

   assign in_ready = adv1_s;
   assign accept_s = in_valid & adv1_s;

   // Stage-1 occupancy: reloads from in_valid on every advance, so a bubble clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_r <= 1'b0;
      end else if (adv1_s) begin
         v1_r <= in_valid;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [7:0] x_s;
      logic [7:0] addr_s;
      logic [7:0] rom_q_r;
      logic [1:0] sel_r;
      logic [7:0] rot_s;

      // s4 is s1 of the input rotated left by one, folded into the address.
      assign x_s    = in_data[8*i +: 8];
      assign addr_s = (in_sel[2*i +: 2] == 2'd3) ? {x_s[6:0], x_s[7]} : x_s;

      // Synchronous-read ROM; read enable holds the output during a stall.
      always_ff @(posedge clk) begin
         if (accept_s) begin
            rom_q_r <= SBOX1[addr_s];
         end
      end

      // Sideband select travelling alongside the ROM read.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sel_r <= 2'd0;
         end else if (accept_s) begin
            sel_r <= in_sel[2*i +: 2];
         end
      end

      // Post-rotation of the ROM byte for s2 (left) and s3 (right).
      always_comb begin
         rot_s = rom_q_r;
         case (sel_r)
            2'd1:    rot_s = {rom_q_r[6:0], rom_q_r[7]};
            2'd2:    rot_s = {rom_q_r[0], rom_q_r[7:1]};
            default: rot_s = rom_q_r;
         endcase
      end

      assign rot_all_s[8*i +: 8] = rot_s;
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic               v2_r;
      logic               adv2_s;
      logic [8*LANES-1:0] out_r;

      assign adv2_s    = ~v2_r | out_ready;
      assign adv1_s    = ~v1_r | adv2_s;
      assign out_valid = v2_r;
      assign out_data  = out_r;

      // Output stage: takes the rotated bytes when stage 1 moves forward.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v2_r  <= 1'b0;
            out_r <= {(8*LANES){1'b0}};
         end else if (adv2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
               out_r <= rot_all_s;
            end
         end
      end
   end else begin : g_no_out_reg
      assign adv1_s    = ~v1_r | out_ready;
      assign out_valid = v1_r;
      assign out_data  = rot_all_s;
   end

endmodule

// File: tb/tb_camellia_sbox_array.sv
// Directed bench for camellia_sbox_array: an 8-lane registered-output instance and a
// 1-lane unregistered instance share handshake stimulus; a negedge scoreboard tracks order.
module tb_camellia_sbox_array;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] in_data;
   logic [15:0] in_sel;
   logic        in_ready_a;
   logic        out_valid_a;
   logic [63:0] out_data_a;
   logic        in_ready_b;
   logic        out_valid_b;
   logic [7:0]  out_data_b;

   int checks   = 0;
   int failures = 0;

   logic [63:0] qa [$];
   logic [7:0]  qb [$];

   int ref_tab [256] = '{
      112, 130, 44,  236, 179, 39,  192, 229, 228, 133, 87,  53,  234, 12,  174, 65,
      35,  239, 107, 147, 69,  25,  165, 33,  237, 14,  79,  78,  29,  101, 146, 189,
      134, 184, 175, 143, 124, 235, 31,  206, 62,  48,  220, 95,  94,  197, 11,  26,
      166, 225, 57,  202, 213, 71,  93,  61,  217, 1,   90,  214, 81,  86,  108, 77,
      139, 13,  154, 102, 251, 204, 176, 45,  116, 18,  43,  32,  240, 177, 132, 153,
      223, 76,  203, 194, 52,  126, 118, 5,   109, 183, 169, 49,  209, 23,  4,   215,
      20,  88,  58,  97,  222, 27,  17,  28,  50,  15,  156, 22,  83,  24,  242, 34,
      254, 68,  207, 178, 195, 181, 122, 145, 36,  8,   232, 168, 96,  252, 105, 80,
      170, 208, 160, 125, 161, 137, 98,  151, 84,  91,  30,  149, 224, 255, 100, 210,
      16,  196, 0,   72,  163, 247, 117, 219, 138, 3,   230, 218, 9,   63,  221, 148,
      135, 92,  131, 2,   205, 74,  144, 51,  115, 103, 246, 243, 157, 127, 191, 226,
      82,  155, 216, 38,  200, 55,  198, 59,  129, 150, 111, 75,  19,  190, 99,  46,
      233, 121, 167, 140, 159, 110, 188, 142, 41,  245, 249, 182, 47,  253, 180, 89,
      120, 152, 6,   106, 231, 70,  113, 186, 212, 37,  171, 66,  136, 162, 141, 250,
      114, 7,   185, 85,  248, 238, 172, 10,  54,  73,  42,  104, 60,  56,  241, 164,
      64,  40,  211, 123, 187, 201, 67,  193, 21,  227, 173, 244, 119, 199, 128, 158
   };

   camellia_sbox_array #(.LANES(8), .OUT_REG(1)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid_a),
      .out_ready (out_ready),
      .out_data  (out_data_a)
   );

   camellia_sbox_array #(.LANES(1), .OUT_REG(0)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_b),
      .in_data   (in_data[7:0]),
      .in_sel    (in_sel[1:0]),
      .out_valid (out_valid_b),
      .out_ready (out_ready),
      .out_data  (out_data_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] sfun(input logic [7:0] x, input logic [1:0] sel);
      logic [7:0] t;
      case (sel)
         2'd0: t = 8'(ref_tab[x]);
         2'd1: begin t = 8'(ref_tab[x]); t = {t[6:0], t[7]}; end
         2'd2: begin t = 8'(ref_tab[x]); t = {t[0], t[7:1]}; end
         default: t = 8'(ref_tab[{x[6:0], x[7]}]);
      endcase
      return t;
   endfunction

   function automatic logic [63:0] model_a(input logic [63:0] d, input logic [15:0] s);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = sfun(d[8*i +: 8], s[2*i +: 2]);
      return r;
   endfunction

   // Scoreboard sampled mid-cycle: check head while valid, pop on drain, push on accept.
   always @(negedge clk) begin
      if (rst) begin
         qa.delete();
         qb.delete();
      end else begin
         if (out_valid_a) begin
            if (qa.size() == 0) check_eq("spurious_a", 64'(out_valid_a), 64'd0);
            else begin
               check_eq("sb_a", out_data_a, qa[0]);
               if (out_ready) void'(qa.pop_front());
            end
         end
         if (out_valid_b) begin
            if (qb.size() == 0) check_eq("spurious_b", 64'(out_valid_b), 64'd0);
            else begin
               check_eq("sb_b", 64'(out_data_b), 64'(qb[0]));
               if (out_ready) void'(qb.pop_front());
            end
         end
         if (in_valid && in_ready_a) qa.push_back(model_a(in_data, in_sel));
         if (in_valid && in_ready_b) qb.push_back(sfun(in_data[7:0], in_sel[1:0]));
      end
   end

   task automatic xact(input string tag, input logic [63:0] d, input logic [15:0] s,
                       input logic [63:0] exp);
      int lat_a;
      int lat_b;
      lat_a = 0;
      lat_b = 0;
      in_valid = 1'b1; in_data = d; in_sel = s; out_ready = 1'b1;
      check_eq({tag, "_rdy"}, 64'(in_ready_a & in_ready_b), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (out_valid_a && lat_a == 0) begin
            lat_a = c;
            check_eq({tag, "_a"}, out_data_a, exp);
         end
         if (out_valid_b && lat_b == 0) begin
            lat_b = c;
            check_eq({tag, "_b"}, 64'(out_data_b), 64'(exp[7:0]));
         end
         @(posedge clk); #1;
      end
      check_eq({tag, "_lat_a"}, 64'(lat_a), 64'd2);
      check_eq({tag, "_lat_b"}, 64'(lat_b), 64'd1);
   endtask

   initial begin
      int n_valid_a, n_valid_b, first, last, n_nordy, acc_a, acc_b;
      clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_data = 64'd0; in_sel = 16'd0;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid_a", 64'(out_valid_a), 64'd0);
      check_eq("rst_out_data_a", out_data_a, 64'd0);
      check_eq("rst_out_valid_b", 64'(out_valid_b), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("idle_in_ready_a", 64'(in_ready_a), 64'd1);
      check_eq("idle_in_ready_b", 64'(in_ready_b), 64'd1);

      // Function and rotation placement
      xact("func_mix", 64'd0, 16'h39E4, 64'h7070_38E0_7038_E070);
      xact("s1_01", {8{8'h01}}, 16'h0000, {8{8'h82}});
      xact("s2_01", {8{8'h01}}, 16'h5555, {8{8'h05}});
      xact("s3_01", {8{8'h01}}, 16'hAAAA, {8{8'h41}});
      xact("s4_80", {8{8'h80}}, 16'hFFFF, {8{8'h82}});
      xact("s1_ff", {8{8'hFF}}, 16'h0000, {8{8'h9E}});
      xact("mix_ff", {8{8'hFF}}, 16'hE4E4, 64'h9E4F_3D9E_9E4F_3D9E);

      // Streaming the full byte range at full rate
      out_ready = 1'b1;
      n_valid_a = 0; n_valid_b = 0; first = -1; last = -1; n_nordy = 0;
      for (int c = 0; c < 262; c++) begin
         if (c < 256) begin
            in_valid = 1'b1; in_data = {8{8'(c)}}; in_sel = 16'd0;
            if (!(in_ready_a && in_ready_b)) n_nordy++;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid_a) begin
            n_valid_a++;
            if (first < 0) first = c;
            last = c;
         end
         if (out_valid_b) n_valid_b++;
         @(posedge clk); #1;
      end
      check_eq("stream_count_a", 64'(n_valid_a), 64'd256);
      check_eq("stream_count_b", 64'(n_valid_b), 64'd256);
      check_eq("stream_span_a", 64'(last - first + 1), 64'd256);
      check_eq("stream_no_stall", 64'(n_nordy), 64'd0);

      // Backpressure
      out_ready = 1'b0; acc_a = 0; acc_b = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_data = {8{8'(8'h10 + c)}}; in_sel = {8{2'(c)}};
         if (in_ready_a) acc_a++;
         if (in_ready_b) acc_b++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check_eq("bp_accepts_a", 64'(acc_a), 64'd2);
      check_eq("bp_accepts_b", 64'(acc_b), 64'd1);
      check_eq("bp_hold_a", out_data_a, {8{8'h23}});
      check_eq("bp_hold_b", 64'(out_data_b), 64'h23);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_second_a", out_data_a, {8{8'hDF}});
      check_eq("bp_second_valid_a", 64'(out_valid_a), 64'd1);
      check_eq("bp_drained_b", 64'(out_valid_b), 64'd0);
      @(posedge clk); #1;
      check_eq("bp_drained_a", 64'(out_valid_a), 64'd0);

      // Reset with both stages full
      out_ready = 1'b0; in_valid = 1'b1; in_sel = 16'd0;
      in_data = {8{8'h20}};
      @(posedge clk); #1;
      in_data = {8{8'h21}};
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("full_valid_a", 64'(out_valid_a), 64'd1);
      check_eq("full_ready_a", 64'(in_ready_a), 64'd0);
      rst = 1'b1;
      #1;
      check_eq("mrst_valid_a", 64'(out_valid_a), 64'd0);
      check_eq("mrst_data_a", out_data_a, 64'd0);
      check_eq("mrst_valid_b", 64'(out_valid_b), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("post_rst_idle_a", 64'(out_valid_a), 64'd0);
      check_eq("post_rst_idle_b", 64'(out_valid_b), 64'd0);
      xact("post_rst", {8{8'h02}}, 16'h0000, {8{8'h2C}});

      check_eq("sb_empty_a", 64'(qa.size()), 64'd0);
      check_eq("sb_empty_b", 64'(qb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
